mips150_mem_stage: RTL and testbench
====================================

Name: mips150_mem_stage

Overview:
- Memory-access stage sitting directly downstream of the MIPS150 control decoder and the ALU.
- Consumes the decoder's MemWrite, Mask, MemtoReg and RegWrite together with the ALU address and store data.
- Drives the synchronous data BRAM: byte write enables, word address and lane-replicated store data.
- Registers the M/W pipeline boundary and produces aligned, sign/zero-extended writeback data.

Parameters:
- DMEM_AW, 12, width of the word address presented to data memory (addr[DMEM_AW+1:2]).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  holds the M-stage register; upstream holds its inputs while high.
- alu_addr  in  32  effective address / ALU result from X stage.
- store_data  in  32  rt value for stores.
- mem_write  in  2  00 none, 01 SB, 10 SH, 11 SW.
- mask  in  3  000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU; ignored unless mem_to_reg=1.
- mem_to_reg  in  1  instruction is a load.
- reg_write  in  1  instruction writes a register.
- wa  in  5  destination register.
- dmem_we  out  4  byte write enables; bit 3 = byte at offset 0 (big-endian).
- dmem_addr  out  DMEM_AW  word address.
- dmem_din  out  32  lane-replicated store data.
- dmem_dout  in  32  BRAM read data, valid one cycle after dmem_addr.
- wb_reg_write  out  1  registered write strobe for the register file.
- wb_wa  out  5  registered destination register.
- wb_data  out  32  writeback value.
- misalign_err  out  1  one-cycle misalignment flag (see Optional Feature).

Behaviour:
- X-side outputs are combinational from the inputs:
  - dmem_addr = alu_addr[DMEM_AW+1:2].
  - SB: din = {4{b}}, we = 1000 >> off.
  - SH: din = {2{h}}, we = 1100 when addr[1]=0, 0011 when addr[1]=1.
  - SW: we = 1111, din = store_data.
  - mem_write=00: we = 0000.
- stall=1 forces dmem_we=0000.
- M-stage register fields: mload, mmask, moff[1:0], malu[31:0], mwa, mrw.
  - Loads when stall=0; holds when stall=1.
  - Reset clears all fields to 0.
- Outputs from the M-stage register:
  - wb_reg_write = mrw, wb_wa = mwa.
  - Both are forced 0 while stall=1, so no duplicate writes.
- wb_data:
  - mload=0: wb_data = malu.
  - mload=1: lane selected by moff, big-endian. Byte lane = bits [31-8*off -: 8]. Half lane = [31:16] if moff[1]=0, else [15:0].
  - Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes the full word.
  - Mask values 101–111 behave as LW.
- Load latency: a load presented in cycle N yields wb_data in cycle N+1 with no bubble.
- Stall read-data hold:
  - In the first stall cycle with mload=1, latch dmem_dout into rd_hold and set hold_v=1.
  - While hold_v=1, extraction uses rd_hold instead of dmem_dout.
  - hold_v clears on the first cycle stall=0.
- Reset values: wb_reg_write=0, wb_wa=0, wb_data=0, misalign_err=0, hold_v=0, rd_hold=0.
- Reset mid-stall drops hold_v and the held instruction.
- Back-to-back store then load to the same word: the load returns the BRAM read-before-write result. No forwarding.

Optional Feature:
- Macro: MEM_MISALIGN_EN.
- Defined:
  - Misaligned means halfword access with addr[0]=1, or word access with addr[1:0]≠00.
  - A misaligned store forces dmem_we=0000.
  - A misaligned load or store clears mrw on capture.
  - misalign_err pulses high for one cycle, the cycle after capture, and is not asserted while stalled.
- Undefined: low address bits beyond the access size are ignored. Halfword uses addr[1]; word uses addr[1:0]=00. misalign_err is tied 0.

Test Plan:
- SB store_data=0x000000A5, addr=0x102 -> dmem_we=0010, dmem_din=0xA5A5A5A5, dmem_addr=0x040.
- LB addr=0x3 with dmem_dout=0x123456F0 the next cycle -> wb_data=0xFFFFFFF0, wb_reg_write=1, in cycle N+1.
- LHU addr=0x0, dmem_dout=0x8001FFFF -> wb_data=0x00008001.
- LW addr=0x8, then stall=1 for 3 cycles with dmem_dout changed to 0xDEADBEEF after the first stall cycle -> wb_data stays at the original word. wb_reg_write=0 while stalled, 1 for one cycle after release.
- MEM_MISALIGN_EN defined, SW addr=0x6 -> dmem_we=0000, misalign_err=1 for one cycle, wb_reg_write=0. Undefined: dmem_we=1111, dmem_addr=0x001.
- rst_n low mid-stall with a pending load -> all outputs 0 immediately (asynchronous). After release, the first ADDIU (alu_addr=0x55, reg_write=1) gives wb_data=0x55.

Source files
------------

// File: rtl/mips150_mem_stage.sv
// mips150_mem_stage: memory-access stage of the MIPS150 pipeline.
//   X side (combinational): byte enables, word address and lane-replicated
//   store data for the synchronous data BRAM.
//   M side (registered): M/W boundary register and aligned, sign/zero
//   extended writeback data taken from the BRAM read port.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   stall                 holds the M register and suppresses side effects
//   alu_addr, store_data  address/ALU result and store value from X
//   mem_write, mask       store size (00/SB/SH/SW) and load type
//   mem_to_reg, reg_write load flag and register-write flag
//   wa                    destination register
//   dmem_we/addr/din      BRAM write enables (bit 3 = offset 0), address, data
//   dmem_dout             BRAM read data, one cycle after dmem_addr
//   wb_reg_write, wb_wa, wb_data  writeback strobe, register, value
//   misalign_err          one-cycle misaligned-access flag
// Build option: define MEM_MISALIGN_EN to detect misaligned halfword/word
// accesses; otherwise low address bits beyond the access size are ignored.
module mips150_mem_stage #(
  parameter int DMEM_AW = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic [31:0]        alu_addr,
  input  logic [31:0]        store_data,
  input  logic [1:0]         mem_write,
  input  logic [2:0]         mask,
  input  logic               mem_to_reg,
  input  logic               reg_write,
  input  logic [4:0]         wa,
  output logic [3:0]         dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [31:0]        dmem_din,
  input  logic [31:0]        dmem_dout,
  output logic               wb_reg_write,
  output logic [4:0]         wb_wa,
  output logic [31:0]        wb_data,
  output logic               misalign_err
);

  logic [1:0]  off;
  logic        misal;
  logic [3:0]  we_raw;

  assign off       = alu_addr[1:0];
  assign dmem_addr = alu_addr[DMEM_AW+1:2];

`ifdef MEM_MISALIGN_EN
  always_comb begin
    misal = 1'b0;
    if (mem_write == 2'b10)
      misal = alu_addr[0];
    else if (mem_write == 2'b11)
      misal = |off;
    else if (mem_to_reg) begin
      case (mask)
        3'b000, 3'b011: misal = 1'b0;
        3'b001, 3'b100: misal = alu_addr[0];
        default:        misal = |off;    // LW and the LW-aliased encodings
      endcase
    end
  end
`else
  assign misal = 1'b0;
`endif

  always_comb begin
    we_raw   = 4'b0000;
    dmem_din = store_data;
    case (mem_write)
      2'b01: begin
        we_raw   = 4'b1000 >> off;
        dmem_din = {4{store_data[7:0]}};
      end
      2'b10: begin
        we_raw   = off[1] ? 4'b0011 : 4'b1100;
        dmem_din = {2{store_data[15:0]}};
      end
      2'b11:   we_raw = 4'b1111;
      default: we_raw = 4'b0000;
    endcase
  end

  assign dmem_we = (stall || misal) ? 4'b0000 : we_raw;

  // M-stage register
  logic        mload_q;
  logic [2:0]  mmask_q;
  logic [1:0]  moff_q;
  logic [31:0] malu_q;
  logic [4:0]  mwa_q;
  logic        mrw_q;
  logic        merr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mload_q <= 1'b0;
      mmask_q <= 3'b000;
      moff_q  <= 2'b00;
      malu_q  <= 32'h0;
      mwa_q   <= 5'd0;
      mrw_q   <= 1'b0;
      merr_q  <= 1'b0;
    end else if (!stall) begin
      mload_q <= mem_to_reg;
      mmask_q <= mask;
      moff_q  <= off;
      malu_q  <= alu_addr;
      mwa_q   <= wa;
      mrw_q   <= reg_write && !misal;
      merr_q  <= misal;
    end
  end

  // The BRAM output only reflects the load address in the first M cycle;
  // once stalled, upstream may re-present other addresses, so freeze it.
  logic        hold_v_q, hold_v_d;
  logic [31:0] rd_hold_q, rd_hold_d;

  always_comb begin
    hold_v_d  = hold_v_q;
    rd_hold_d = rd_hold_q;
    if (!stall)
      hold_v_d = 1'b0;
    else if (mload_q && !hold_v_q) begin
      hold_v_d  = 1'b1;
      rd_hold_d = dmem_dout;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_v_q  <= 1'b0;
      rd_hold_q <= 32'h0;
    end else begin
      hold_v_q  <= hold_v_d;
      rd_hold_q <= rd_hold_d;
    end
  end

  logic [31:0] rd;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] ld_val;

  assign rd      = hold_v_q ? rd_hold_q : dmem_dout;
  assign rd_half = moff_q[1] ? rd[15:0] : rd[31:16];

  always_comb begin
    case (moff_q)
      2'd0:    rd_byte = rd[31:24];
      2'd1:    rd_byte = rd[23:16];
      2'd2:    rd_byte = rd[15:8];
      default: rd_byte = rd[7:0];
    endcase
  end

  always_comb begin
    case (mmask_q)
      3'b000:  ld_val = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  ld_val = {{16{rd_half[15]}}, rd_half};
      3'b011:  ld_val = {24'h0, rd_byte};
      3'b100:  ld_val = {16'h0, rd_half};
      default: ld_val = rd;
    endcase
  end

  assign wb_data      = mload_q ? ld_val : malu_q;
  assign wb_reg_write = mrw_q && !stall;
  assign wb_wa        = stall ? 5'd0 : mwa_q;

`ifdef MEM_MISALIGN_EN
  assign misalign_err = merr_q && !stall;
`else
  assign misalign_err = 1'b0 & merr_q;
`endif

endmodule

// File: tb/tb_mips150_mem_stage.sv
module tb_mips150_mem_stage;

  logic        clk, rst_n, stall;
  logic [31:0] alu_addr, store_data, dmem_din, dmem_dout, wb_data;
  logic [1:0]  mem_write;
  logic [2:0]  mask;
  logic        mem_to_reg, reg_write, wb_reg_write, misalign_err;
  logic [4:0]  wa, wb_wa;
  logic [3:0]  dmem_we;
  logic [11:0] dmem_addr;

  int total = 0;
  int bad   = 0;
  logic cmp_en = 1'b0;

  mips150_mem_stage #(.DMEM_AW(12)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .alu_addr(alu_addr),
    .store_data(store_data), .mem_write(mem_write), .mask(mask),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .wa(wa),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_din(dmem_din),
    .dmem_dout(dmem_dout), .wb_reg_write(wb_reg_write), .wb_wa(wb_wa),
    .wb_data(wb_data), .misalign_err(misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic bit is_misaligned(input logic [1:0] mw, input logic [2:0] mk,
                                       input logic ld, input logic [31:0] a);
`ifdef MEM_MISALIGN_EN
    int size;
    size = 0;
    if (mw == 2'b01) size = 1;
    else if (mw == 2'b10) size = 2;
    else if (mw == 2'b11) size = 4;
    else if (ld) size = (mk == 3'b000 || mk == 3'b011) ? 1 :
                        (mk == 3'b001 || mk == 3'b100) ? 2 : 4;
    return size != 0 && (a % size) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [3:0] model_we(input logic [1:0] mw, input logic [31:0] a,
                                          input logic stl, input bit mis);
    int o;
    o = a % 4;
    if (stl || mis) return 4'd0;
    case (mw)
      2'b01:   return 4'(8 >> o);
      2'b10:   return (o >= 2) ? 4'd3 : 4'd12;
      2'b11:   return 4'd15;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] model_din(input logic [1:0] mw, input logic [31:0] sd);
    if (mw == 2'b01) return (sd % 256) * 32'h01010101;
    if (mw == 2'b10) return (sd % 65536) * 32'h00010001;
    return sd;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] mk, input int o,
                                             input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (3 - o))) & 32'hFF;
    h = (w >> (16 * (1 - o / 2))) & 32'hFFFF;
    case (mk)
      3'b000:  return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'b001:  return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'b011:  return b;
      3'b100:  return h;
      default: return w;
    endcase
  endfunction

  // record of the instruction sitting in M; age 0 = first cycle in M
  logic        m_load, m_rw, m_err;
  logic [2:0]  m_mask;
  logic [31:0] m_addr, m_word;
  logic [4:0]  m_wa;
  int          m_age;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load <= 0; m_rw <= 0; m_err <= 0; m_mask <= 0;
      m_addr <= 0; m_word <= 0; m_wa <= 0; m_age <= 1;
    end else begin
      if (m_age == 0) m_word <= dmem_dout;
      if (!stall) begin
        m_load <= mem_to_reg;
        m_mask <= mask;
        m_addr <= alu_addr;
        m_wa   <= wa;
        m_err  <= is_misaligned(mem_write, mask, mem_to_reg, alu_addr);
        m_rw   <= reg_write && !is_misaligned(mem_write, mask, mem_to_reg, alu_addr);
        m_age  <= 0;
      end else if (m_age < 2) m_age <= m_age + 1;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      logic [31:0] exp_wb;
      bit mis;
      mis = is_misaligned(mem_write, mask, mem_to_reg, alu_addr);
      exp_wb = m_load ? model_load(m_mask, int'(m_addr % 4), (m_age == 0) ? dmem_dout : m_word)
                      : m_addr;
      check("m_we",   {28'h0, dmem_we}, {28'h0, model_we(mem_write, alu_addr, stall, mis)});
      check("m_addr", {20'h0, dmem_addr}, (alu_addr / 4) % 4096);
      if (mem_write != 2'b00)
        check("m_din", dmem_din, model_din(mem_write, store_data));
      check("m_wbrw", {31'h0, wb_reg_write}, {31'h0, m_rw && !stall});
      check("m_wbwa", {27'h0, wb_wa}, stall ? 32'h0 : {27'h0, m_wa});
      check("m_wbdata", wb_data, exp_wb);
      check("m_mis", {31'h0, misalign_err}, {31'h0, m_err && !stall});
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic [1:0]  mw;
    logic [2:0]  mk;
    logic        ld;
    logic        rw;
    logic [4:0]  w;
    logic [31:0] a;
    logic [31:0] sd;
    logic [31:0] dout;   // BRAM data returned the following cycle
  } vec_t;

  vec_t tbl[12];

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #1;
  endtask

  task automatic drv(input logic [1:0] mw, input logic [2:0] mk, input logic ld,
                     input logic rw, input logic [4:0] w, input logic [31:0] a,
                     input logic [31:0] sd);
    mem_write = mw; mask = mk; mem_to_reg = ld; reg_write = rw;
    wa = w; alu_addr = a; store_data = sd;
  endtask

  task automatic nop();
    drv(2'b00, 3'b000, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  initial begin
    rst_n = 0; stall = 0; dmem_dout = 0;
    nop();
    tbl[0]  = '{2'b00, 3'b000, 1, 1, 5'd1, 32'h201, 0, 32'h12F45678};
    tbl[1]  = '{2'b00, 3'b011, 1, 1, 5'd2, 32'h202, 0, 32'h1234A678};
    tbl[2]  = '{2'b00, 3'b001, 1, 1, 5'd3, 32'h022, 0, 32'h1234F678};
    tbl[3]  = '{2'b00, 3'b100, 1, 1, 5'd4, 32'h026, 0, 32'h1234F678};
    tbl[4]  = '{2'b00, 3'b010, 1, 1, 5'd5, 32'h030, 0, 32'hCAFEBABE};
    tbl[5]  = '{2'b00, 3'b111, 1, 1, 5'd6, 32'h034, 0, 32'h01020304};
    tbl[6]  = '{2'b00, 3'b000, 0, 1, 5'd8, 32'hABCD1234, 0, 32'h0};
    tbl[7]  = '{2'b10, 3'b000, 0, 0, 5'd0, 32'h400, 32'h1234BEEF, 32'h0};
    tbl[8]  = '{2'b10, 3'b000, 0, 0, 5'd0, 32'h402, 32'h1234BEEF, 32'h0};
    tbl[9]  = '{2'b01, 3'b000, 0, 0, 5'd0, 32'h007, 32'h0000005A, 32'h0};
    tbl[10] = '{2'b11, 3'b000, 0, 0, 5'd0, 32'h800, 32'h87654321, 32'h0};
    tbl[11] = '{2'b00, 3'b000, 1, 1, 5'd9, 32'h000, 0, 32'h7F000000};

    cyc(); cyc();
    at_neg();
    check("rst_wbdata", wb_data, 32'h0);
    check("rst_wbrw", {31'h0, wb_reg_write}, 32'h0);
    check("rst_wbwa", {27'h0, wb_wa}, 32'h0);
    check("rst_mis", {31'h0, misalign_err}, 32'h0);
    cyc();
    rst_n = 1; cmp_en = 1;

    // SB
    drv(2'b01, 3'b000, 0, 0, 5'd0, 32'h102, 32'h000000A5);
    at_neg();
    check("sb_we", {28'h0, dmem_we}, 32'h2);
    check("sb_din", dmem_din, 32'hA5A5A5A5);
    check("sb_addr", {20'h0, dmem_addr}, 32'h040);
    cyc();

    // LB, one-cycle latency
    drv(2'b00, 3'b000, 1, 1, 5'd5, 32'h3, 32'h0);
    cyc(); nop(); dmem_dout = 32'h123456F0;
    at_neg();
    check("lb_data", wb_data, 32'hFFFFFFF0);
    check("lb_rw", {31'h0, wb_reg_write}, 32'h1);
    check("lb_wa", {27'h0, wb_wa}, 32'h5);
    cyc();

    // LHU
    drv(2'b00, 3'b100, 1, 1, 5'd6, 32'h0, 32'h0);
    cyc(); nop(); dmem_dout = 32'h8001FFFF;
    at_neg();
    check("lhu_data", wb_data, 32'h00008001);
    cyc();

    // LW followed by a 3-cycle stall; BRAM output changes under the stall
    drv(2'b00, 3'b010, 1, 1, 5'd7, 32'h8, 32'h0);
    cyc();
    drv(2'b00, 3'b000, 0, 1, 5'd9, 32'h99, 32'h0);
    stall = 1; dmem_dout = 32'h11223344;
    at_neg();
    check("lw_st1_data", wb_data, 32'h11223344);
    check("lw_st1_rw", {31'h0, wb_reg_write}, 32'h0);
    cyc(); dmem_dout = 32'hDEADBEEF;
    at_neg();
    check("lw_st2_data", wb_data, 32'h11223344);
    cyc();
    at_neg();
    check("lw_st3_data", wb_data, 32'h11223344);
    check("lw_st3_rw", {31'h0, wb_reg_write}, 32'h0);
    cyc(); stall = 0;
    at_neg();
    check("lw_rel_data", wb_data, 32'h11223344);
    check("lw_rel_rw", {31'h0, wb_reg_write}, 32'h1);
    check("lw_rel_wa", {27'h0, wb_wa}, 32'h7);
    cyc(); nop();
    at_neg();
    check("addiu_data", wb_data, 32'h99);
    check("addiu_wa", {27'h0, wb_wa}, 32'h9);
    cyc();

    // misaligned SW and LW
    drv(2'b11, 3'b000, 0, 0, 5'd0, 32'h6, 32'h11111111);
    at_neg();
`ifdef MEM_MISALIGN_EN
    check("sw_mis_we", {28'h0, dmem_we}, 32'h0);
`else
    check("sw_mis_we", {28'h0, dmem_we}, 32'hF);
`endif
    check("sw_mis_addr", {20'h0, dmem_addr}, 32'h001);
    cyc();
    drv(2'b00, 3'b010, 1, 1, 5'd10, 32'h6, 32'h0);
    at_neg();
`ifdef MEM_MISALIGN_EN
    check("sw_mis_err", {31'h0, misalign_err}, 32'h1);
`else
    check("sw_mis_err", {31'h0, misalign_err}, 32'h0);
`endif
    check("sw_mis_rw", {31'h0, wb_reg_write}, 32'h0);
    cyc(); nop(); dmem_dout = 32'h0BADF00D;
    at_neg();
`ifdef MEM_MISALIGN_EN
    check("lw_mis_rw", {31'h0, wb_reg_write}, 32'h0);
`else
    check("lw_mis_rw", {31'h0, wb_reg_write}, 32'h1);
`endif
    check("lw_mis_data", wb_data, 32'h0BADF00D);
    cyc();

    // directed table, checked by the model every cycle
    for (int i = 0; i <= 12; i++) begin
      if (i < 12) drv(tbl[i].mw, tbl[i].mk, tbl[i].ld, tbl[i].rw, tbl[i].w, tbl[i].a, tbl[i].sd);
      else nop();
      dmem_dout = (i > 0) ? tbl[i-1].dout : 32'h0;
      if (i == 1) begin
        at_neg();
        check("tbl_lb_off1", wb_data, 32'hFFFFFFF4);
      end
      if (i == 12) begin
        at_neg();
        check("tbl_lb_pos", wb_data, 32'h0000007F);
      end
      cyc();
    end

    // reset in the middle of a stalled load
    drv(2'b00, 3'b010, 1, 1, 5'd3, 32'h10, 32'h0);
    cyc(); nop(); stall = 1; dmem_dout = 32'hCAFEF00D;
    at_neg();
    check("pre_rst_data", wb_data, 32'hCAFEF00D);
    cyc(); #1;
    rst_n = 0;
    #1;
    check("midrst_data", wb_data, 32'h0);
    check("midrst_rw", {31'h0, wb_reg_write}, 32'h0);
    check("midrst_wa", {27'h0, wb_wa}, 32'h0);
    check("midrst_mis", {31'h0, misalign_err}, 32'h0);
    cyc(); cyc();
    rst_n = 1; stall = 0;
    drv(2'b00, 3'b000, 0, 1, 5'd4, 32'h55, 32'h0);
    cyc(); nop();
    at_neg();
    check("post_rst_data", wb_data, 32'h55);
    check("post_rst_rw", {31'h0, wb_reg_write}, 32'h1);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
